// File: rtl/btn_conditioner.sv
// Direction-button conditioner: a 2-FF synchroniser, a debounce filter and a press/auto-repeat FSM per button.
// Emits one-cycle move strobes and cancels the strobes of opposing directions.
module btn_conditioner #(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int HOLD_CYCLES     = 20_000_000,
    parameter int REPEAT_CYCLES   = 4_000_000
) (
    input  logic             pixclk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] move_stb
);

    localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int TMR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX);

    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST   = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] REPEAT_LAST = TMR_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT
    } state_t;

    logic [N_BTN-1:0] sync1_q, sync1_d;
    logic [N_BTN-1:0] sync2_q, sync2_d;
    logic [N_BTN-1:0] level_q, level_d;
    logic [CNT_W-1:0] cnt_q   [N_BTN];
    logic [CNT_W-1:0] cnt_d   [N_BTN];
    state_t           state_q [N_BTN];
    state_t           state_d [N_BTN];
    logic [TMR_W-1:0] tmr_q   [N_BTN];
    logic [TMR_W-1:0] tmr_d   [N_BTN];
    logic [N_BTN-1:0] raw_stb;
    logic [N_BTN-1:0] move_stb_q, move_stb_d;

    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
    end

    // The debounce count restarts whenever the synchronised input agrees with the level again.
    always_comb begin
        level_d = level_q;
        for (int i = 0; i < N_BTN; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                level_d[i] = sync2_q[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // Release takes priority over the terminal count, so a late release never produces a strobe.
    always_comb begin
        raw_stb = '0;
        for (int i = 0; i < N_BTN; i++) begin
            state_d[i] = state_q[i];
            tmr_d[i]   = tmr_q[i];
            case (state_q[i])
                IDLE: begin
                    if (level_q[i]) begin
                        raw_stb[i] = 1'b1;
                        tmr_d[i]   = '0;
                        state_d[i] = HOLD;
                    end
                end
                HOLD: begin
                    if (!level_q[i]) begin
                        state_d[i] = IDLE;
                    end else if (tmr_q[i] == HOLD_LAST) begin
                        raw_stb[i] = 1'b1;
                        tmr_d[i]   = '0;
                        state_d[i] = REPEAT;
                    end else begin
                        tmr_d[i] = tmr_q[i] + 1'b1;
                    end
                end
                REPEAT: begin
                    if (!level_q[i]) begin
                        state_d[i] = IDLE;
                    end else if (tmr_q[i] == REPEAT_LAST) begin
                        raw_stb[i] = 1'b1;
                        tmr_d[i]   = '0;
                    end else begin
                        tmr_d[i] = tmr_q[i] + 1'b1;
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    tmr_d[i]   = '0;
                end
            endcase
        end
    end

    // Opposing pairs are {up,down} and {left,right}; coincident requests cancel each other.
    always_comb begin
        move_stb_d = raw_stb;
        for (int i = 0; i + 1 < N_BTN; i += 2) begin
            if (raw_stb[i] && raw_stb[i+1]) begin
                move_stb_d[i]   = 1'b0;
                move_stb_d[i+1] = 1'b0;
            end
        end
    end

    always_ff @(posedge pixclk) begin
        if (!rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            level_q    <= '0;
            move_stb_q <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i]   <= '0;
                state_q[i] <= IDLE;
                tmr_q[i]   <= '0;
            end
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            level_q    <= level_d;
            move_stb_q <= move_stb_d;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i]   <= cnt_d[i];
                state_q[i] <= state_d[i];
                tmr_q[i]   <= tmr_d[i];
            end
        end
    end

    assign btn_level = level_q;
    assign move_stb  = move_stb_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner: the driver queues expected strobes with their cycle numbers,
// and the monitor checks every strobe the DUT presents against the queue.
module tb_btn_conditioner;

    logic       pixclk;
    logic       rst;
    logic [3:0] btn_raw;
    logic [3:0] btn_level;
    logic [3:0] move_stb;

    typedef struct {
        int         cyc;
        logic [3:0] stb;
    } exp_t;

    exp_t expq[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    btn_conditioner #(
        .N_BTN(4),
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES(10),
        .REPEAT_CYCLES(3)
    ) dut (
        .pixclk(pixclk),
        .rst(rst),
        .btn_raw(btn_raw),
        .btn_level(btn_level),
        .move_stb(move_stb)
    );

    initial begin
        pixclk = 1'b0;
        forever #5 pixclk = ~pixclk;
    end

    // cyc is the number of rising edges so far; it is sampled on falling edges.
    always @(posedge pixclk) cyc <= cyc + 1;

    always @(negedge pixclk) begin
        if (move_stb != 4'b0000) begin
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_strobe: cycle %0d move_stb=%b, none expected", cyc, move_stb);
            end else begin
                exp_t e;
                e = expq.pop_front();
                if (e.cyc != cyc || move_stb !== e.stb) begin
                    errors++;
                    $display("[TB] FAIL strobe: got cycle %0d move_stb=%b, expected cycle %0d move_stb=%b",
                             cyc, move_stb, e.cyc, e.stb);
                end
            end
        end
    end

    task automatic waitCyc(input int t);
        while (cyc < t) @(negedge pixclk);
    endtask

    task automatic applyStimulus(input logic [3:0] raw);
        btn_raw = raw;
    endtask

    task automatic pushExp(input int c, input logic [3:0] s);
        exp_t e;
        e.cyc = c;
        e.stb = s;
        expq.push_back(e);
    endtask

    task automatic checkOutput(input string name, input logic [3:0] mask, input logic [3:0] expected);
        checks++;
        if ((btn_level & mask) !== expected) begin
            errors++;
            $display("[TB] FAIL %s: cycle %0d btn_level&%b=%b, expected %b",
                     name, cyc, mask, btn_level & mask, expected);
        end
    endtask

    initial begin
        int e;
        rst = 1'b0;
        applyStimulus(4'hF);

        // 1: reset holds everything low; afterwards all four rise together and cancel pairwise.
        for (int k = 1; k <= 5; k++) begin
            waitCyc(k);
            checkOutput("reset_level", 4'hF, 4'h0);
        end
        rst = 1'b1;
        e = cyc + 1;
        waitCyc(e + 4);
        checkOutput("t1_level_before", 4'hF, 4'h0);
        waitCyc(e + 5);
        checkOutput("t1_level_rise", 4'hF, 4'hF);
        waitCyc(30);
        applyStimulus(4'h0);
        waitCyc(36);
        checkOutput("t1_level_fall", 4'hF, 4'h0);

        // 2: bouncing input on bit 0, then a clean press released before auto-repeat.
        for (int k = 0; k < 10; k++) begin
            waitCyc(40 + 2 * k);
            applyStimulus((k % 2 == 0) ? 4'b0001 : 4'b0000);
            checkOutput("t2_bounce_level", 4'b0001, 4'b0000);
        end
        waitCyc(60);
        applyStimulus(4'b0001);
        e = cyc + 1;
        pushExp(e + 6, 4'b0001);
        waitCyc(e + 4);
        checkOutput("t2_level_before", 4'b0001, 4'b0000);
        waitCyc(e + 5);
        checkOutput("t2_level_rise", 4'b0001, 4'b0001);
        waitCyc(e + 8);
        applyStimulus(4'b0000);
        waitCyc(e + 14);
        checkOutput("t2_level_fall", 4'b0001, 4'b0000);
        waitCyc(e + 30);

        // 3: three-cycle glitch on bit 2 is shorter than the debounce window.
        applyStimulus(4'b0100);
        e = cyc + 1;
        waitCyc(e + 2);
        applyStimulus(4'b0000);
        for (int k = 3; k <= 8; k++) begin
            waitCyc(e + k);
            checkOutput("t3_glitch_level", 4'b0100, 4'b0000);
        end
        waitCyc(e + 20);

        // 4: auto-repeat on bit 3; the release lands on the terminal-count cycle at e+46.
        applyStimulus(4'b1000);
        e = cyc + 1;
        pushExp(e + 6, 4'b1000);
        pushExp(e + 16, 4'b1000);
        for (int t = e + 19; t <= e + 43; t += 3) pushExp(t, 4'b1000);
        waitCyc(e + 39);
        applyStimulus(4'b0000);
        waitCyc(e + 44);
        checkOutput("t4_level_held", 4'b1000, 4'b1000);
        waitCyc(e + 45);
        checkOutput("t4_level_fall", 4'b1000, 4'b0000);
        waitCyc(e + 60);

        // 5: left+right pressed together cancel; releasing bit 0 lets bit 1 repeat on its own phase.
        applyStimulus(4'b0011);
        e = cyc + 1;
        for (int t = e + 28; t <= e + 40; t += 3) pushExp(t, 4'b0010);
        waitCyc(e + 4);
        checkOutput("t5_level_before", 4'b0011, 4'b0000);
        waitCyc(e + 5);
        checkOutput("t5_level_rise", 4'b0011, 4'b0011);
        waitCyc(e + 19);
        applyStimulus(4'b0010);
        waitCyc(e + 24);
        checkOutput("t5_bit0_held", 4'b0011, 4'b0011);
        waitCyc(e + 25);
        checkOutput("t5_bit0_fall", 4'b0011, 4'b0010);
        waitCyc(e + 35);
        applyStimulus(4'b0000);
        waitCyc(e + 41);
        checkOutput("t5_bit1_fall", 4'b0011, 4'b0000);
        waitCyc(e + 55);

        // 6: reset pulse mid-REPEAT suppresses the due strobe and restarts debounce from scratch.
        applyStimulus(4'b0001);
        e = cyc + 1;
        pushExp(e + 6, 4'b0001);
        pushExp(e + 16, 4'b0001);
        pushExp(e + 19, 4'b0001);
        pushExp(e + 29, 4'b0001);
        waitCyc(e + 21);
        rst = 1'b0;
        waitCyc(e + 22);
        rst = 1'b1;
        checkOutput("t6_level_cleared", 4'hF, 4'h0);
        checks++;
        if (move_stb !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL t6_stb_in_reset: move_stb=%b, expected 0000", move_stb);
        end
        waitCyc(e + 27);
        checkOutput("t6_level_before", 4'b0001, 4'b0000);
        waitCyc(e + 28);
        checkOutput("t6_level_rise", 4'b0001, 4'b0001);
        waitCyc(e + 32);
        applyStimulus(4'b0000);
        waitCyc(e + 50);

        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("[TB] FAIL missing_strobes: %0d left in queue, expected 0 (next due cycle %0d)",
                     expq.size(), expq[0].cyc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
